// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, EX/MEM forwarding select and jump flush
// control for a short in-order pipeline.
// Optional feature macro: HAZARD_STATS_EN adds saturating stallCount and
// flushCount event counters.
module hazard_ctrl #(
  parameter int FLUSH_DEPTH = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       idValid,
  input  logic       idUsesRs,
  input  logic [1:0] idRs,
  input  logic       exWR,
  input  logic       exRM,
  input  logic [1:0] exRd,
  input  logic       memWR,
  input  logic [1:0] memRd,
  input  logic       exJump,
  input  logic       exJumpC,
  input  logic       zeroOut,
  output logic [1:0] fwd,
  output logic       stall,
  output logic       bubble,
  output logic       flush,
  output logic [1:0] state
`ifdef HAZARD_STATS_EN
  ,
  output logic [7:0] stallCount,
  output logic [7:0] flushCount
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } stateT;

  // A one-cycle flush never leaves RUN; longer flushes park in FLUSH and the
  // counter covers the remaining cycles after the first FLUSH cycle.
  localparam bit         JUMP_ENTERS_FLUSH = (FLUSH_DEPTH > 1);
  localparam logic [1:0] CNT_INIT = JUMP_ENTERS_FLUSH ? 2'(FLUSH_DEPTH - 2) : 2'd0;

  stateT      stateQ;
  stateT      stateNext;
  logic [1:0] cntQ;
  logic [1:0] cntNext;
  logic [1:0] fwdNext;
  logic       takenJump;
  logic       loadUse;
  logic       stallRaw;
  logic       flushRaw;
  logic       exHit;
  logic       memHit;

  // Next-state and raw control outputs of the hazard FSM.
  always_comb begin
    takenJump = exJump | (exJumpC & zeroOut);
    loadUse   = idValid & idUsesRs & exWR & exRM & (exRd == idRs);
    stateNext = stateQ;
    cntNext   = cntQ;
    stallRaw  = 1'b0;
    flushRaw  = 1'b0;
    case (stateQ)
      RUN: begin
        if (takenJump) begin
          // A taken jump wins over a load-use hazard: the consumer is flushed.
          flushRaw = 1'b1;
          if (JUMP_ENTERS_FLUSH) begin
            stateNext = FLUSH;
            cntNext   = CNT_INIT;
          end else begin
            stateNext = RUN;
          end
        end else if (loadUse) begin
          stallRaw  = 1'b1;
          stateNext = STALL;
        end else begin
          stateNext = RUN;
        end
      end
      STALL: begin
        stateNext = RUN;
      end
      FLUSH: begin
        flushRaw = 1'b1;
        if (cntQ == 2'd0) begin
          stateNext = RUN;
        end else begin
          cntNext = cntQ - 2'd1;
        end
      end
      default: begin
        stateNext = RUN;
        cntNext   = 2'd0;
      end
    endcase
  end

  // Reset masks the combinational controls in the cycle it is asserted.
  always_comb begin
    if (reset) begin
      stall  = 1'b0;
      bubble = 1'b0;
      flush  = 1'b0;
    end else begin
      stall  = stallRaw;
      bubble = stallRaw;
      flush  = flushRaw;
    end
  end

  // Forward select for the ID instruction once it reaches EX; EX beats MEM.
  always_comb begin
    exHit  = idUsesRs & exWR & ~exRM & (exRd == idRs);
    memHit = idUsesRs & memWR & (memRd == idRs);
    if (~idValid | (stateQ == FLUSH) | flushRaw) begin
      fwdNext = 2'b00;
    end else if (exHit) begin
      fwdNext = 2'b01;
    end else if (memHit) begin
      fwdNext = 2'b10;
    end else begin
      fwdNext = 2'b00;
    end
  end

  // State, flush counter and forward select registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ <= RUN;
      cntQ   <= 2'd0;
      fwd    <= 2'b00;
    end else begin
      stateQ <= stateNext;
      cntQ   <= cntNext;
      if (!stallRaw) begin
        fwd <= fwdNext;
      end else begin
        fwd <= fwd;
      end
    end
  end

  assign state = stateQ;

`ifdef HAZARD_STATS_EN
  // Saturating counters of accepted stalls and accepted jumps.
  always_ff @(posedge clock) begin
    if (reset) begin
      stallCount <= 8'd0;
      flushCount <= 8'd0;
    end else begin
      if (stallRaw && (stallCount != 8'd255)) begin
        stallCount <= stallCount + 8'd1;
      end else begin
        stallCount <= stallCount;
      end
      if ((stateQ == RUN) && takenJump && (flushCount != 8'd255)) begin
        flushCount <= flushCount + 8'd1;
      end else begin
        flushCount <= flushCount;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (FLUSH_DEPTH=3) against a cycle-level
// behavioural model; directed scenarios pin exact values, random traffic
// exercises the rest.
module tb_hazard_ctrl;
  localparam int DEPTH = 3;

  logic       clock = 1'b0;
  logic       reset, idValid, idUsesRs, exWR, exRM, memWR, exJump, exJumpC, zeroOut;
  logic [1:0] idRs, exRd, memRd;
  logic [1:0] fwd, state;
  logic       stall, bubble, flush;
`ifdef HAZARD_STATS_EN
  logic [7:0] stallCount, flushCount;
`endif

  hazard_ctrl #(.FLUSH_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .idValid(idValid), .idUsesRs(idUsesRs),
    .idRs(idRs), .exWR(exWR), .exRM(exRM), .exRd(exRd), .memWR(memWR),
    .memRd(memRd), .exJump(exJump), .exJumpC(exJumpC), .zeroOut(zeroOut),
    .fwd(fwd), .stall(stall), .bubble(bubble), .flush(flush), .state(state)
`ifdef HAZARD_STATS_EN
    , .stallCount(stallCount), .flushCount(flushCount)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Literal expectations posted by the stimulus, consumed at the next negedge.
  int         pinSeq  = 0;
  int         pinDone = 0;
  string      pinName;
  logic [5:0] pinMask;   // {stallCount, fwd, state, flush, bubble, stall}
  logic       pinStall, pinBubble, pinFlush;
  logic [1:0] pinState, pinFwd;
  logic [7:0] pinSc;

  // Behavioural model: remaining forced-flush cycles, one pending stall slot.
  int         mFlushLeft = 0;
  bit         mInStall   = 1'b0;
  bit         mKnown     = 1'b0;
  logic [1:0] mFwd       = 2'b00;
  int         mStallCnt  = 0;
  int         mFlushCnt  = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs with the model every cycle, then advance the model.
  always @(negedge clock) begin
    bit tj, lu, eStall, eFlush, inFlush;
    logic [1:0] eState;
    tj      = exJump | (exJumpC & zeroOut);
    lu      = idValid & idUsesRs & exWR & exRM & (exRd == idRs);
    inFlush = (mFlushLeft > 0);
    eState  = inFlush ? 2'b10 : (mInStall ? 2'b01 : 2'b00);
    eFlush  = !reset && (inFlush || (!mInStall && tj));
    eStall  = !reset && !inFlush && !mInStall && lu && !tj;

    chk("stall", {7'd0, stall}, {7'd0, eStall});
    chk("bubble", {7'd0, bubble}, {7'd0, eStall});
    chk("flush", {7'd0, flush}, {7'd0, eFlush});
    if (mKnown) begin
      chk("state", {6'd0, state}, {6'd0, eState});
      chk("fwd", {6'd0, fwd}, {6'd0, mFwd});
`ifdef HAZARD_STATS_EN
      chk("stallCount", stallCount, 8'(mStallCnt));
      chk("flushCount", flushCount, 8'(mFlushCnt));
`endif
    end

    if (pinSeq != pinDone) begin
      if (pinMask[0]) chk({pinName, ".stall"}, {7'd0, stall}, {7'd0, pinStall});
      if (pinMask[1]) chk({pinName, ".bubble"}, {7'd0, bubble}, {7'd0, pinBubble});
      if (pinMask[2]) chk({pinName, ".flush"}, {7'd0, flush}, {7'd0, pinFlush});
      if (pinMask[3]) chk({pinName, ".state"}, {6'd0, state}, {6'd0, pinState});
      if (pinMask[4]) chk({pinName, ".fwd"}, {6'd0, fwd}, {6'd0, pinFwd});
`ifdef HAZARD_STATS_EN
      if (pinMask[5]) chk({pinName, ".stallCount"}, stallCount, pinSc);
`endif
      pinDone = pinSeq;
    end

    if (reset) begin
      mFlushLeft = 0;
      mInStall   = 1'b0;
      mFwd       = 2'b00;
      mKnown     = 1'b1;
      mStallCnt  = 0;
      mFlushCnt  = 0;
    end else begin
      if (!eStall) begin
        if (inFlush || !idValid || eFlush) mFwd = 2'b00;
        else if (idUsesRs && exWR && !exRM && exRd == idRs) mFwd = 2'b01;
        else if (idUsesRs && memWR && memRd == idRs) mFwd = 2'b10;
        else mFwd = 2'b00;
      end
      if (inFlush) begin
        mFlushLeft = mFlushLeft - 1;
      end else if (mInStall) begin
        mInStall = 1'b0;
      end else if (tj) begin
        mFlushLeft = DEPTH - 1;
        if (mFlushCnt < 255) mFlushCnt++;
      end else if (lu) begin
        mInStall = 1'b1;
        if (mStallCnt < 255) mStallCnt++;
      end
    end
  end

  task automatic pin(input string name, input logic [5:0] mask, input logic s, input logic b,
                     input logic f, input logic [1:0] st, input logic [1:0] fw, input logic [7:0] sc);
    pinName   = name;
    pinMask   = mask;
    pinStall  = s;
    pinBubble = b;
    pinFlush  = f;
    pinState  = st;
    pinFwd    = fw;
    pinSc     = sc;
    pinSeq++;
  endtask

  task automatic idle();
    reset = 1'b0; idValid = 1'b0; idUsesRs = 1'b0; idRs = 2'd0;
    exWR = 1'b0; exRM = 1'b0; exRd = 2'd0; memWR = 1'b0; memRd = 2'd0;
    exJump = 1'b0; exJumpC = 1'b0; zeroOut = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic loadUseIn(input logic [1:0] r);
    idValid = 1'b1; idUsesRs = 1'b1; idRs = r; exWR = 1'b1; exRM = 1'b1; exRd = r;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    pin("rst", 6'b000111, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'd0);
    tick();
    tick();
    reset = 1'b0;
    pin("rst_state", 6'b011000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'd0);
    tick();

    // EX ALU result forwarding.
    idValid = 1'b1; idUsesRs = 1'b1; idRs = 2'd2; exWR = 1'b1; exRM = 1'b0; exRd = 2'd2;
    pin("exfwd", 6'b001101, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'd0);
    tick();
    idle();
    pin("exfwd_next", 6'b010000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 8'd0);
    tick();

    // Load-use stall then MEM forwarding.
    loadUseIn(2'd1);
    pin("lu", 6'b001111, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 8'd0);
    tick();
    exWR = 1'b0; exRM = 1'b0; memWR = 1'b1; memRd = 2'd1;
    pin("lu_stall", 6'b001111, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 8'd0);
    tick();
    idle();
    pin("lu_after", 6'b011000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 8'd0);
    tick();

    // Conditional jump: three flush cycles, two in FLUSH, load-use ignored.
    exJumpC = 1'b1; zeroOut = 1'b1;
    pin("jc0", 6'b001101, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 8'd0);
    tick();
    idle(); loadUseIn(2'd3);
    pin("jc1", 6'b001111, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 8'd0);
    tick();
    idle();
    pin("jc2", 6'b001101, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 8'd0);
    tick();
    pin("jc3", 6'b001101, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'd0);
    tick();

    // Jump beats load-use in the same cycle.
    loadUseIn(2'd0); exJump = 1'b1;
    pin("jlu", 6'b001111, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 8'd0);
    tick();
    idle();
    pin("jlu_next", 6'b001000, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 8'd0);
    tick();
    tick();
    tick();

    // Reset in the second flush cycle.
    idValid = 1'b1; idUsesRs = 1'b1; idRs = 2'd3; exWR = 1'b1; exRd = 2'd3;
    tick();
    idle(); exJump = 1'b1;
    pin("rj0", 6'b011100, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 8'd0);
    tick();
    idle(); reset = 1'b1;
    pin("rj1", 6'b001111, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 8'd0);
    tick();
    idle();
    pin("rj2", 6'b011111, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'd0);
    tick();

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      idValid  = ($urandom_range(0, 7) != 0);
      idUsesRs = ($urandom_range(0, 3) != 0);
      idRs     = 2'($urandom_range(0, 3));
      exWR     = $urandom_range(0, 1) == 1;
      exRM     = $urandom_range(0, 1) == 1;
      exRd     = 2'($urandom_range(0, 3));
      memWR    = $urandom_range(0, 1) == 1;
      memRd    = 2'($urandom_range(0, 3));
      exJump   = ($urandom_range(0, 11) == 0);
      exJumpC  = ($urandom_range(0, 5) == 0);
      zeroOut  = $urandom_range(0, 1) == 1;
      tick();
    end

`ifdef HAZARD_STATS_EN
    idle(); reset = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 300; i++) begin
      loadUseIn(2'(i % 4));
      tick();
      idle();
      tick();
    end
    pin("sat", 6'b100000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'd255);
    tick();
`endif

    idle();
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: FLUSH_DEPTH, default 2, total cycles flush is asserted per taken jump; legal range 1..4.
REQ-002 Port: clock  in  1  sole clock; all state updates on posedge clock.
REQ-003 Port: reset  in  1  synchronous, active-high reset, sampled on posedge clock.
REQ-004 Port: idValid  in  1  ID-stage holds a valid instruction.
REQ-005 Port: idUsesRs  in  1  ID-stage instruction reads register idRs.
REQ-006 Port: idRs  in  2  source register of the ID-stage instruction.
REQ-007 Port: exWR, exRM  in  1 each  EX-stage instruction writes a register / is a memory load.
REQ-008 Port: exRd  in  2  destination register of the EX-stage instruction.
REQ-009 Port: memWR  in  1, memRd  in  2  MEM-stage write enable and destination register.
REQ-010 Port: exJump, exJumpC, zeroOut  in  1 each  unconditional jump, conditional jump, and zero flag in EX.
REQ-011 Port: fwd  out  2  registered forward select for EX: 00 register value, 01 acOut, 10 memory data; 11 never driven.
REQ-012 Port: stall  out  1  hold PC and IF/ID register this cycle.
REQ-013 Port: bubble  out  1  zero the control bits entering EX on the next edge.
REQ-014 Port: flush  out  1  invalidate IF and ID instructions this cycle.
REQ-015 Port: state  out  2  FSM state: 00 RUN, 01 STALL, 10 FLUSH.

Function
REQ-016 takenJump = exJump | (exJumpC & zeroOut).
REQ-017 loadUse = idValid & idUsesRs & exWR & exRM & (exRd == idRs).
REQ-018 In RUN, stall and bubble equal loadUse & ~takenJump, driven combinationally in the same cycle.
REQ-019 In RUN, flush equals takenJump, driven combinationally; takenJump has priority over loadUse.
REQ-020 RUN -> FLUSH on takenJump when FLUSH_DEPTH > 1, loading a down-counter with FLUSH_DEPTH-2; RUN stays RUN on takenJump when FLUSH_DEPTH == 1.
REQ-021 RUN -> STALL on loadUse & ~takenJump.
REQ-022 STALL lasts exactly one cycle: stall=0, bubble=0, flush=0; next state RUN.
REQ-023 FLUSH: flush=1, stall=0, bubble=0, loadUse and takenJump ignored; exits to RUN the cycle after the counter reads 0.
REQ-024 fwd updates only on edges where stall is 0; fwd holds its value on edges where stall is 1.
REQ-025 In RUN or STALL, next fwd = 01 if idUsesRs & exWR & ~exRM & exRd==idRs; else 10 if idUsesRs & memWR & memRd==idRs; else 00.
REQ-026 EX match has priority over MEM match when both hit the same register.
REQ-027 When ~idValid, or in FLUSH, or when flush=1 in RUN, next fwd = 00.
REQ-028 Leaving STALL, the load has moved to MEM, so REQ-025 yields 10 for the stalled consumer.

Reset
REQ-029 reset=1 at a clock edge: state=RUN, fwd=00, flush counter=0, statistics counters=0; takes priority over every other transition.
REQ-030 stall, bubble and flush are 0 in any cycle with reset=1, including reset asserted mid-STALL or mid-FLUSH.

Configuration
REQ-031 Macro HAZARD_STATS_EN defined: adds outputs stallCount (8) and flushCount (8).
REQ-032 With HAZARD_STATS_EN, stallCount increments on each RUN->STALL transition and flushCount on each takenJump accepted in RUN; both saturate at 255 and clear only on reset.
REQ-033 Without HAZARD_STATS_EN, both ports and their counters are absent; all other behaviour is identical.

Verification
REQ-034 Bench: exWR=1, exRM=0, exRd=2, idRs=2, idUsesRs=1, idValid=1 -> stall=0; fwd=01 after the next edge.
REQ-035 Bench: exWR=1, exRM=1, exRd=1, idRs=1 -> stall=bubble=1 for one cycle; state 01; then fwd=10 and state 00.
REQ-036 Bench: FLUSH_DEPTH=3, exJumpC=1, zeroOut=1 -> flush=1 for exactly 3 consecutive cycles; state 10 for 2 cycles; loadUse inside FLUSH gives stall=0.
REQ-037 Bench: loadUse and exJump in the same cycle -> flush=1, stall=0, next state FLUSH.
REQ-038 Bench: reset asserted in the second FLUSH cycle -> next cycle state=00, flush=0, fwd=00.
REQ-039 Bench (HAZARD_STATS_EN): 300 load-use events -> stallCount=255.
